// File: rtl/param_data_cache.sv
// Write-back, write-allocate data cache with 1- or 2-way sets and 4-byte blocks.
// Optional hit/miss counters are included when CACHE_STATS_EN is defined.
module param_data_cache #(
    parameter int ADDR_W   = 8,
    parameter int SET_BITS = 3,
    parameter int WAYS     = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [7:0]        WRITEDATA,
    output logic [7:0]        READDATA,
    output logic              BUSYWAIT,
    output logic              mem_READ,
    output logic              mem_WRITE,
    output logic [ADDR_W-3:0] mem_ADDRESS,
    output logic [31:0]       mem_WRITEDATA,
    input  logic [31:0]       mem_READDATA,
    input  logic              mem_BUSYWAIT
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_W - SET_BITS - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

    state_t            state;
    logic [SETS-1:0]   valid    [WAYS];
    logic [SETS-1:0]   dirty    [WAYS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [31:0]       data_mem [WAYS][SETS];
    logic [SETS-1:0]   lru;          // per set: index of the least-recently-used way
    logic              victim_way;

    logic [1:0]          offset;
    logic [SET_BITS-1:0] index;
    logic [TAG_W-1:0]    req_tag;
    logic                req;

    assign offset  = ADDRESS[1:0];
    assign index   = ADDRESS[SET_BITS+1:2];
    assign req_tag = ADDRESS[ADDR_W-1:SET_BITS+2];
    assign req     = READ | WRITE;

    logic        hit;
    logic        hit_way;
    logic [31:0] hit_block;
    logic        victim_way_c;
    logic        v_dirty;
    logic [TAG_W-1:0] v_tag;
    logic [31:0] v_block;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        hit       = 1'b0;
        hit_way   = 1'b0;
        hit_block = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][index] && tag_mem[w][index] == req_tag) begin
                hit       = 1'b1;
                hit_way   = 1'(w);
                hit_block = data_mem[w][index];
            end
        end
    end

    // Prefer the lowest-numbered invalid way; otherwise evict the LRU way.
    always_comb begin
        victim_way_c = (WAYS == 2) ? lru[index] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][index]) victim_way_c = 1'(w);
        end
        v_dirty = 1'b0;
        v_tag   = '0;
        v_block = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (victim_way_c == 1'(w)) begin
                v_dirty = valid[w][index] & dirty[w][index];
                v_tag   = tag_mem[w][index];
                v_block = data_mem[w][index];
            end
        end
    end

    assign READDATA = (state == IDLE && READ && !WRITE && hit) ? hit_block[{offset, 3'b000} +: 8] : 8'h00;
    assign BUSYWAIT = RESET & ((state != IDLE) | (req & ~hit));

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            mem_READ      <= 1'b0;
            mem_WRITE     <= 1'b0;
            mem_ADDRESS   <= '0;
            mem_WRITEDATA <= '0;
            victim_way    <= 1'b0;
            lru           <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                dirty[w] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (WRITE && hit_way == 1'(w)) dirty[w][index] <= 1'b1;
                        end
                        lru[index] <= ~hit_way;
                    end else if (req) begin
                        victim_way    <= victim_way_c;
                        mem_WRITEDATA <= v_block;
                        mem_ADDRESS   <= v_dirty ? {v_tag, index} : {req_tag, index};
                        mem_WRITE     <= v_dirty;
                        mem_READ      <= ~v_dirty;
                        state         <= v_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (!mem_BUSYWAIT) begin
                        mem_WRITE   <= 1'b0;
                        mem_READ    <= 1'b1;
                        mem_ADDRESS <= {req_tag, index};
                        state       <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (!mem_BUSYWAIT) begin
                        mem_READ <= 1'b0;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (victim_way == 1'(w)) begin
                            valid[w][index] <= 1'b1;
                            dirty[w][index] <= 1'b0;
                        end
                    end
                    lru[index] <= ~victim_way;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone make them meaningful.
    always_ff @(posedge CLK) begin
        for (int w = 0; w < WAYS; w++) begin
            if (state == IDLE && WRITE && hit && hit_way == 1'(w))
                data_mem[w][index][{offset, 3'b000} +: 8] <= WRITEDATA;
            if (state == UPDATE && victim_way == 1'(w)) begin
                data_mem[w][index] <= mem_READDATA;
                tag_mem[w][index]  <= req_tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // The hit that completes a refilled request belongs to the miss already counted.
    logic fill_done;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
            fill_done  <= 1'b0;
        end else begin
            fill_done <= (state == UPDATE);
            if (state == IDLE && req) begin
                if (hit) begin
                    if (!fill_done && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                end else if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_data_cache.sv
// Bench for param_data_cache: directed vector table, reset-in-ALLOCATE sequence and
// randomized accesses against a recency-list cache model plus a flat memory image.
module tb_param_data_cache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = '0;
    logic [7:0]  WRITEDATA = '0;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_READ;
    logic        mem_WRITE;
    logic [5:0]  mem_ADDRESS;
    logic [31:0] mem_WRITEDATA;
    logic [31:0] mem_READDATA = '0;
    logic        mem_BUSYWAIT;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int failures = 0;

    param_data_cache #(.ADDR_W(8), .SET_BITS(3), .WAYS(2)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .mem_READ(mem_READ), .mem_WRITE(mem_WRITE), .mem_ADDRESS(mem_ADDRESS),
        .mem_WRITEDATA(mem_WRITEDATA), .mem_READDATA(mem_READDATA), .mem_BUSYWAIT(mem_BUSYWAIT)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Backing memory: a request is busy for 5 edges, then completes on the 6th.
    logic [7:0] mem_bytes [256];
    int         lat_cnt = 0;
    logic [6:0] ev_q [$];   // {is_write, block address} of each memory request seen

    assign mem_BUSYWAIT = (mem_READ || mem_WRITE) && lat_cnt != 5;

    always @(posedge CLK) begin
        if (mem_READ || mem_WRITE) begin
            if (lat_cnt == 5) begin
                lat_cnt <= 0;
                if (mem_WRITE) begin
                    for (int b = 0; b < 4; b++) mem_bytes[int'(mem_ADDRESS) * 4 + b] <= mem_WRITEDATA[8*b +: 8];
                end else begin
                    for (int b = 0; b < 4; b++) mem_READDATA[8*b +: 8] <= mem_bytes[int'(mem_ADDRESS) * 4 + b];
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    always @(negedge CLK)
        if ((mem_READ || mem_WRITE) && lat_cnt == 0) ev_q.push_back({mem_WRITE, mem_ADDRESS});

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the access has been accepted.
    task automatic access(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                          output logic missed, output logic [7:0] rd);
        int n;
        ev_q.delete();
        READ = ~wr; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
        @(negedge CLK);
        missed = BUSYWAIT;
        n = 0;
        while (BUSYWAIT && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("busy_timeout", {31'd0, BUSYWAIT}, 32'd0);
        rd = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic check_events(input string tag, input logic miss, input logic wb,
                                input logic [5:0] wb_addr, input logic [5:0] blk);
        int n_exp;
        n_exp = !miss ? 0 : (wb ? 2 : 1);
        check($sformatf("%s_nev", tag), ev_q.size(), n_exp);
        if (ev_q.size() == n_exp && n_exp > 0) begin
            if (wb) begin
                check($sformatf("%s_wb", tag), {25'd0, ev_q[0]}, {25'd0, 1'b1, wb_addr});
                check($sformatf("%s_rd_after_wb", tag), {25'd0, ev_q[1]}, {25'd0, 1'b0, blk});
            end else begin
                check($sformatf("%s_fill", tag), {25'd0, ev_q[0]}, {25'd0, 1'b0, blk});
            end
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       exp_miss;
        logic       exp_wb;
        logic [5:0] wb_addr;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    // Reference model: per-set recency list (oldest first), dirty flag per block, flat memory image.
    int         res    [8][$];
    bit         mdirty [64];
    logic [7:0] arch   [256];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       missed;
        logic [7:0] rd;
        int         n;

        for (int i = 0; i < 256; i++) mem_bytes[i] = init_byte(8'(i));

        vecs[0]  = '{1'b0, 8'h24, 8'h00, 1'b1, 1'b0, 6'h00, init_byte(8'h24)};
        vecs[1]  = '{1'b1, 8'h24, 8'hAB, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[2]  = '{1'b0, 8'h24, 8'h00, 1'b0, 1'b0, 6'h00, 8'hAB};
        vecs[3]  = '{1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 6'h00, init_byte(8'h04)};
        vecs[4]  = '{1'b0, 8'h24, 8'h00, 1'b0, 1'b0, 6'h00, 8'hAB};
        vecs[5]  = '{1'b0, 8'h44, 8'h00, 1'b1, 1'b0, 6'h00, init_byte(8'h44)};
        vecs[6]  = '{1'b0, 8'h24, 8'h00, 1'b0, 1'b0, 6'h00, 8'hAB};
        vecs[7]  = '{1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 6'h00, init_byte(8'h04)};
        vecs[8]  = '{1'b0, 8'h44, 8'h00, 1'b1, 1'b1, 6'h09, init_byte(8'h44)};
        vecs[9]  = '{1'b0, 8'h64, 8'h00, 1'b1, 1'b0, 6'h00, init_byte(8'h64)};
        vecs[10] = '{1'b0, 8'h24, 8'h00, 1'b1, 1'b0, 6'h00, 8'hAB};

        // Reset values, with the clock running and no request.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("rst_mem_read", {31'd0, mem_READ}, 32'd0);
        check("rst_mem_write", {31'd0, mem_WRITE}, 32'd0);
        check("rst_mem_address", {26'd0, mem_ADDRESS}, 32'd0);
        check("rst_mem_writedata", mem_WRITEDATA, 32'd0);
        check("rst_readdata", {24'd0, READDATA}, 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 11; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].wd, missed, rd);
            check($sformatf("vec%0d_miss", i), {31'd0, missed}, {31'd0, vecs[i].exp_miss});
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].exp_rd});
            check_events($sformatf("vec%0d", i), vecs[i].exp_miss, vecs[i].exp_wb,
                         vecs[i].wb_addr, vecs[i].addr[7:2]);
`ifdef CACHE_STATS_EN
            if (i == 2) begin
                check("stats_hits", {16'd0, hit_count}, 32'd2);
                check("stats_misses", {16'd0, miss_count}, 32'd1);
            end
`endif
        end

        // Reset asserted while a refill is outstanding.
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h88;
        n = 0;
        while (!mem_READ && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("alloc_reached", {31'd0, mem_READ}, 32'd1);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("rst_alloc_mem_read", {31'd0, mem_READ}, 32'd0);
        check("rst_alloc_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("rst_alloc_mem_address", {26'd0, mem_ADDRESS}, 32'd0);
        @(posedge CLK);
        #1;
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        access(1'b0, 8'h88, 8'h00, missed, rd);
        check("post_rst_miss", {31'd0, missed}, 32'd1);
        check("post_rst_rdata", {24'd0, rd}, {24'd0, init_byte(8'h88)});

        // Randomized accesses; an empty cache makes memory the architectural truth.
        do_reset();
        for (int s = 0; s < 8; s++) res[s].delete();
        for (int b = 0; b < 64; b++) mdirty[b] = 1'b0;
        for (int a = 0; a < 256; a++) arch[a] = mem_bytes[a];

        for (int i = 0; i < 300; i++) begin
            logic       wr;
            logic [7:0] a;
            logic [7:0] wd;
            logic [7:0] exp_rd;
            logic [5:0] blk;
            logic [5:0] vic;
            int         s;
            int         pos;
            bit         hit;
            bit         wb;

            a  = {2'($urandom_range(0, 3)), 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            wr = ($urandom_range(0, 9) < 4);
            wd = 8'($urandom);

            blk = a[7:2];
            s   = int'(blk[2:0]);
            hit = 1'b0; pos = 0; wb = 1'b0; vic = '0;
            for (int k = 0; k < res[s].size(); k++) begin
                if (res[s][k] == int'(blk)) begin
                    hit = 1'b1;
                    pos = k;
                end
            end
            if (hit) begin
                res[s].delete(pos);
            end else if (res[s].size() == 2) begin
                vic = 6'(res[s].pop_front());
                wb  = mdirty[vic];
                mdirty[vic] = 1'b0;
            end
            res[s].push_back(int'(blk));
            exp_rd = arch[a];
            if (wr) begin
                arch[a]     = wd;
                mdirty[blk] = 1'b1;
            end

            access(wr, a, wd, missed, rd);
            check($sformatf("rnd%0d_miss", i), {31'd0, missed}, {31'd0, !hit});
            if (!wr) check($sformatf("rnd%0d_rdata", i), {24'd0, rd}, {24'd0, exp_rd});
            check_events($sformatf("rnd%0d", i), !hit, wb, vic, blk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_data_cache.md
PARAM_DATA_CACHE -- requirements
Module: param_data_cache

Interface
- REQ-001 SHALL have parameter ADDR_W, default 8, CPU byte-address width.
- REQ-002 SHALL have parameter SET_BITS, default 3, index width; number of sets = 2**SET_BITS.
- REQ-003 SHALL have parameter WAYS, default 2, associativity; the only legal values are 1 and 2.
- REQ-004 SHALL have port CLK, input, 1, single clock; all state changes on rising edge.
- REQ-005 SHALL have port RESET, input, 1, asynchronous active-low reset.
- REQ-006 SHALL have ports READ and WRITE, input, 1 each, CPU access requests.
- REQ-007 SHALL have port ADDRESS, input, ADDR_W, CPU byte address.
- REQ-008 SHALL have port WRITEDATA, input, 8, CPU store data.
- REQ-009 SHALL have port READDATA, output, 8, CPU load data.
- REQ-010 SHALL have port BUSYWAIT, output, 1; while high, the CPU stalls and holds its request.
- REQ-011 SHALL have ports mem_READ and mem_WRITE, output, 1 each, memory requests.
- REQ-012 SHALL have port mem_ADDRESS, output, ADDR_W-2, block address.
- REQ-013 SHALL have ports mem_WRITEDATA (output) and mem_READDATA (input), 32 each, one 4-byte block.
- REQ-014 SHALL have port mem_BUSYWAIT, input, 1; memory is busy while high.

Function
- REQ-015 SHALL split ADDRESS into offset [1:0], index [SET_BITS+1:2] and tag (remaining upper bits); a block is 4 bytes with byte 0 at mem data bits [7:0].
- REQ-016 SHALL store per way per set: valid bit, dirty bit, tag and a 32-bit block; when WAYS=2, SHALL also store one LRU bit per set.
- REQ-017 SHALL detect a hit combinationally as valid and tag-equal in any way of the indexed set.
- REQ-018 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE and UPDATE.
- REQ-019 SHALL, in IDLE, drive BUSYWAIT = (READ|WRITE) & ~hit; in all other states, BUSYWAIT SHALL be 1.
- REQ-020 SHALL drive READDATA combinationally with the hit byte when a read hit occurs, otherwise 8'h00; a read hit SHALL cost zero stall cycles.
- REQ-021 SHALL, on a write hit, update the byte and set dirty at the next rising edge, with no stall.
- REQ-022 SHALL, on any hit, mark the hit way most-recently-used.
- REQ-023 SHALL choose a miss victim as: the first invalid way (way 0 first), else the LRU way.
- REQ-024 SHALL transition IDLE->WRITEBACK on a miss with a dirty victim, and IDLE->ALLOCATE on a miss with a clean or invalid victim.
- REQ-025 SHALL, in WRITEBACK, hold mem_WRITE=1, mem_ADDRESS={victim tag,index} and mem_WRITEDATA=victim block, and advance to ALLOCATE on the first edge where mem_BUSYWAIT=0.
- REQ-026 SHALL, in ALLOCATE, hold mem_READ=1 and mem_ADDRESS={req tag,index}, and advance to UPDATE on the first edge where mem_BUSYWAIT=0.
- REQ-027 SHALL, in UPDATE, deassert both mem requests and write mem_READDATA into the victim way in one cycle with valid=1, dirty=0 and the new tag, then return to IDLE, where the pending request completes as a hit.
- REQ-028 SHALL treat simultaneous READ and WRITE as a WRITE.
- REQ-029 SHALL, in IDLE with no request, hold mem_READ=mem_WRITE=0 and issue no memory traffic.

Reset
- REQ-030 SHALL, on RESET low, immediately and regardless of state: enter IDLE; clear every valid, dirty and LRU bit; set BUSYWAIT=0, mem_READ=0, mem_WRITE=0, mem_ADDRESS=0 and mem_WRITEDATA=0.
- REQ-031 SHALL, when reset occurs mid-WRITEBACK or mid-ALLOCATE, drop the memory request that cycle without completing it; the lost dirty data is accepted.

Configuration
- REQ-032 SHALL, when CACHE_STATS_EN is defined, add 16-bit output ports hit_count and miss_count, reset to 0, that increment once per access resolved in IDLE (hit) or per IDLE->miss transition, and saturate at 16'hFFFF.
- REQ-033 SHALL, when CACHE_STATS_EN is undefined, omit both ports and both counters entirely.

Verification (ADDR_W=8, SET_BITS=3, WAYS=2, memory latency 5 cycles)
- REQ-034 SHALL cover: after reset, READ 8'h24 -> BUSYWAIT high, mem_READ with mem_ADDRESS=6'h09, no mem_WRITE; READDATA equals memory byte 0x24 in the IDLE cycle after UPDATE.
- REQ-035 SHALL cover: WRITE 8'hAB to 8'h24, then READ 8'h24 -> no BUSYWAIT on either access, READDATA=8'hAB.
- REQ-036 SHALL cover: accesses 8'h04, then 8'h24, then 8'h44 (set 1) -> the third access evicts the 8'h04 block (LRU); a re-read of 8'h24 hits.
- REQ-037 SHALL cover: dirty block 8'h24 evicted by accesses to 8'h44 and then 8'h64 -> mem_WRITE with mem_ADDRESS=6'h09 precedes mem_READ; memory byte 0x24 then reads 8'hAB.
- REQ-038 SHALL cover: RESET low during ALLOCATE -> mem_READ=0 and BUSYWAIT=0 immediately; a subsequent READ of the same address misses.
- REQ-039 SHALL cover, with CACHE_STATS_EN defined: the sequence in REQ-034 and REQ-035 -> hit_count=2, miss_count=1.
